// File: rtl/clock_pkg.sv
// Shared types, limits and the 12-hour display conversion for the timekeeper.
package clock_pkg;

  typedef enum logic [1:0] {
    ALM_DISARMED = 2'd0,
    ALM_ARMED    = 2'd1,
    ALM_RINGING  = 2'd2,
    ALM_SNOOZED  = 2'd3
  } alarm_state_t;

  localparam int unsigned MAX_HOUR    = 23;
  localparam int unsigned MAX_MIN_SEC = 59;

  // 0 -> 12, 1..12 unchanged, 13..23 -> hours-12
  function automatic logic [4:0] to_12h(input logic [4:0] h24);
    if (h24 == 5'd0)
      return 5'd12;
    else if (h24 > 5'd12)
      return h24 - 5'd12;
    else
      return h24;
  endfunction

endpackage

// File: rtl/bin2bcd_2digit.sv
// Converts a binary value 0..59 into tens/ones BCD digits.
module bin2bcd_2digit (
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [5:0] rem;

  // Subtract the largest multiple of ten; the remainder is the ones digit
  always_comb begin
    tens = 4'd0;
    rem  = bin;
    if (bin >= 6'd50) begin
      tens = 4'd5;
      rem  = bin - 6'd50;
    end else if (bin >= 6'd40) begin
      tens = 4'd4;
      rem  = bin - 6'd40;
    end else if (bin >= 6'd30) begin
      tens = 4'd3;
      rem  = bin - 6'd30;
    end else if (bin >= 6'd20) begin
      tens = 4'd2;
      rem  = bin - 6'd20;
    end else if (bin >= 6'd10) begin
      tens = 4'd1;
      rem  = bin - 6'd10;
    end
    ones = rem[3:0];
  end

endmodule

// File: rtl/clock_alarm_timekeeper.sv
// 24-hour timekeeper with run/pause, validated time set, 12/24 h display
// and an alarm with snooze and unattended-ring timeout.
module clock_alarm_timekeeper
  import clock_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned SNOOZE_SEC  = 300,
  parameter int unsigned RING_SEC    = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic [5:0] set_seconds,
  output logic       set_err,
  input  logic       alarm_load,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       alarm_arm,
  input  logic       alarm_stop,
  input  logic       alarm_snooze,
  output logic       sec_pulse,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hour_ones,
  output logic [3:0] hour_tens,
  output logic       pm,
  output logic       alarm_ring
);

  localparam int unsigned PW = $clog2(CLK_FREQ_HZ) + 1;
  localparam int unsigned SW = $clog2(SNOOZE_SEC) + 1;
  localparam int unsigned RW = $clog2(RING_SEC) + 1;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_FREQ_HZ - 1);
  localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SEC - 1);
  localparam logic [RW-1:0] RING_LAST   = RW'(RING_SEC - 1);
  localparam logic [4:0]    HOUR_LAST   = 5'(MAX_HOUR);
  localparam logic [5:0]    MS_LAST     = 6'(MAX_MIN_SEC);

  logic [PW-1:0] presc;
  logic [4:0]    hours;
  logic [5:0]    minutes;
  logic [5:0]    seconds;
  logic [4:0]    alm_hours;
  logic [5:0]    alm_minutes;
  logic [SW-1:0] snooze_cnt;
  logic [RW-1:0] ring_cnt;
  alarm_state_t  state;

  logic          tick;
  logic          set_accept;
  logic          set_in_range;
  logic          set_load;
  logic          alarm_match;
  logic [4:0]    hours_disp;

  assign tick         = run && (presc == PRESC_LAST);
  assign set_accept   = set_valid && set_ready;
  assign set_in_range = (set_hours <= HOUR_LAST) && (set_minutes <= MS_LAST) &&
                        (set_seconds <= MS_LAST);
  assign set_load     = set_accept && set_in_range;

  // Divide the board clock down to one tick per second; a load restarts the second
  always_ff @(posedge clk) begin
    if (reset)
      presc <= '0;
    else if (set_load || tick)
      presc <= '0;
    else if (run)
      presc <= presc + PW'(1);
  end

  // Handshake status: ready once out of reset, one-cycle error on a rejected load
  always_ff @(posedge clk) begin
    if (reset) begin
      set_ready <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      set_ready <= 1'b1;
      set_err   <= set_accept && !set_in_range;
    end
  end

  // Time of day: a valid load takes precedence over a coincident tick
  always_ff @(posedge clk) begin
    if (reset) begin
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
    end else if (set_load) begin
      hours   <= set_hours;
      minutes <= set_minutes;
      seconds <= set_seconds;
    end else if (tick) begin
      if (seconds == MS_LAST) begin
        seconds <= '0;
        if (minutes == MS_LAST) begin
          minutes <= '0;
          hours   <= (hours == HOUR_LAST) ? 5'd0 : hours + 5'd1;
        end else begin
          minutes <= minutes + 6'd1;
        end
      end else begin
        seconds <= seconds + 6'd1;
      end
    end
  end

  // Second strobe aligned with the newly visible time; suppressed on a load
  always_ff @(posedge clk) begin
    if (reset)
      sec_pulse <= 1'b0;
    else
      sec_pulse <= tick && !set_load;
  end

  // Alarm time capture; out-of-range values are kept and simply never match
  always_ff @(posedge clk) begin
    if (reset) begin
      alm_hours   <= '0;
      alm_minutes <= '0;
    end else if (alarm_load) begin
      alm_hours   <= alarm_hours;
      alm_minutes <= alarm_minutes;
    end
  end

  assign alarm_match = sec_pulse && (hours == alm_hours) && (minutes == alm_minutes) &&
                       (seconds == 6'd0);

  // Alarm sequencing; disarming overrides every state, stop beats snooze
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ALM_DISARMED;
      ring_cnt   <= '0;
      snooze_cnt <= '0;
    end else if (!alarm_arm) begin
      state <= ALM_DISARMED;
    end else begin
      case (state)
        ALM_DISARMED: state <= ALM_ARMED;
        ALM_ARMED: begin
          if (alarm_match) begin
            state    <= ALM_RINGING;
            ring_cnt <= '0;
          end
        end
        ALM_RINGING: begin
          if (alarm_stop) begin
            state <= ALM_ARMED;
          end else if (alarm_snooze) begin
            state      <= ALM_SNOOZED;
            snooze_cnt <= '0;
          end else if (sec_pulse) begin
            if (ring_cnt == RING_LAST)
              state <= ALM_ARMED;
            else
              ring_cnt <= ring_cnt + RW'(1);
          end
        end
        ALM_SNOOZED: begin
          if (alarm_stop) begin
            state <= ALM_ARMED;
          end else if (sec_pulse) begin
            if (snooze_cnt == SNOOZE_LAST) begin
              state    <= ALM_RINGING;
              ring_cnt <= '0;
            end else begin
              snooze_cnt <= snooze_cnt + SW'(1);
            end
          end
        end
        default: state <= ALM_DISARMED;
      endcase
    end
  end

  assign alarm_ring = (state == ALM_RINGING);

  assign hours_disp = mode_12h ? to_12h(hours) : hours;
  assign pm         = (hours >= 5'd12);

  bin2bcd_2digit u_sec_bcd (
    .bin  (seconds),
    .tens (sec_tens),
    .ones (sec_ones)
  );

  bin2bcd_2digit u_min_bcd (
    .bin  (minutes),
    .tens (min_tens),
    .ones (min_ones)
  );

  bin2bcd_2digit u_hour_bcd (
    .bin  ({1'b0, hours_disp}),
    .tens (hour_tens),
    .ones (hour_ones)
  );

endmodule

// File: tb/tb_clock_alarm_timekeeper.sv
// Directed bench for clock_alarm_timekeeper with a 4-cycle second.
module tb_clock_alarm_timekeeper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       mode_12h = 1'b0;
  logic       set_valid = 1'b0;
  logic       set_ready;
  logic [4:0] set_hours = '0;
  logic [5:0] set_minutes = '0;
  logic [5:0] set_seconds = '0;
  logic       set_err;
  logic       alarm_load = 1'b0;
  logic [4:0] alarm_hours = '0;
  logic [5:0] alarm_minutes = '0;
  logic       alarm_arm = 1'b0;
  logic       alarm_stop = 1'b0;
  logic       alarm_snooze = 1'b0;
  logic       sec_pulse;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;
  logic       pm;
  logic       alarm_ring;
  logic [23:0] disp;

  int checks = 0;
  int errors = 0;

  assign disp = {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones};

  always #5 clk = ~clk;

  clock_alarm_timekeeper #(
    .CLK_FREQ_HZ (4),
    .SNOOZE_SEC  (3),
    .RING_SEC    (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .mode_12h      (mode_12h),
    .set_valid     (set_valid),
    .set_ready     (set_ready),
    .set_hours     (set_hours),
    .set_minutes   (set_minutes),
    .set_seconds   (set_seconds),
    .set_err       (set_err),
    .alarm_load    (alarm_load),
    .alarm_hours   (alarm_hours),
    .alarm_minutes (alarm_minutes),
    .alarm_arm     (alarm_arm),
    .alarm_stop    (alarm_stop),
    .alarm_snooze  (alarm_snooze),
    .sec_pulse     (sec_pulse),
    .sec_ones      (sec_ones),
    .sec_tens      (sec_tens),
    .min_ones      (min_ones),
    .min_tens      (min_tens),
    .hour_ones     (hour_ones),
    .hour_tens     (hour_tens),
    .pm            (pm),
    .alarm_ring    (alarm_ring)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_set(input int h, input int m, input int s);
    set_hours   = 5'(h);
    set_minutes = 6'(m);
    set_seconds = 6'(s);
    set_valid   = 1'b1;
    step();
    set_valid   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (disp !== 24'h000000) begin errors++; $display("FAIL reset_disp: got %h expected 000000", disp); end
    checks++; if (pm !== 1'b0) begin errors++; $display("FAIL reset_pm: got %b expected 0", pm); end
    checks++; if (set_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", set_ready); end
    checks++; if ({sec_pulse, set_err, alarm_ring} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {sec_pulse, set_err, alarm_ring}); end
    mode_12h = 1'b1;
    #1;
    checks++; if (disp !== 24'h120000) begin errors++; $display("FAIL reset_12h: got %h expected 120000", disp); end
    mode_12h = 1'b0;
    reset = 1'b0;
    step();
    checks++; if (set_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", set_ready); end
  endtask

  task automatic test_rollover();
    int pulses = 0;
    do_set(23, 59, 58);
    checks++; if (disp !== 24'h235958 || pm !== 1'b1) begin errors++; $display("FAIL set_235958: got %h pm %b expected 235958 pm 1", disp, pm); end
    run = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (sec_pulse === 1'b1) pulses++;
      checks++; if (sec_pulse !== ((i == 4) || (i == 8))) begin errors++; $display("FAIL rollover_pulse%0d: got %b expected %b", i, sec_pulse, (i == 4) || (i == 8)); end
      if (i == 4) begin
        checks++; if (disp !== 24'h235959) begin errors++; $display("FAIL rollover_mid: got %h expected 235959", disp); end
      end
    end
    run = 1'b0;
    checks++; if (disp !== 24'h000000 || pm !== 1'b0) begin errors++; $display("FAIL rollover_end: got %h pm %b expected 000000 pm 0", disp, pm); end
    checks++; if (pulses != 2) begin errors++; $display("FAIL rollover_count: got %0d expected 2", pulses); end
  endtask

  task automatic test_invalid_set();
    do_set(24, 0, 0);
    checks++; if (set_err !== 1'b1) begin errors++; $display("FAIL set_err_pulse: got %b expected 1", set_err); end
    checks++; if (disp !== 24'h000000) begin errors++; $display("FAIL invalid_unchanged: got %h expected 000000", disp); end
    step();
    checks++; if (set_err !== 1'b0) begin errors++; $display("FAIL set_err_clear: got %b expected 0", set_err); end
    do_set(10, 60, 0);
    checks++; if (set_err !== 1'b1 || disp !== 24'h000000) begin errors++; $display("FAIL invalid_min: got err %b disp %h expected err 1 disp 000000", set_err, disp); end
    mode_12h = 1'b1;
    do_set(12, 30, 0);
    checks++; if (set_err !== 1'b0) begin errors++; $display("FAIL valid_no_err: got %b expected 0", set_err); end
    checks++; if (disp !== 24'h123000 || pm !== 1'b1) begin errors++; $display("FAIL noon_12h: got %h pm %b expected 123000 pm 1", disp, pm); end
    do_set(13, 5, 0);
    checks++; if (disp !== 24'h010500 || pm !== 1'b1) begin errors++; $display("FAIL pm_12h: got %h pm %b expected 010500 pm 1", disp, pm); end
    mode_12h = 1'b0;
    #1;
    checks++; if (disp !== 24'h130500) begin errors++; $display("FAIL back_24h: got %h expected 130500", disp); end
  endtask

  task automatic test_set_tick_collision();
    do_set(10, 0, 0);
    run = 1'b1;
    step();
    step();
    step();
    set_hours   = 5'd5;
    set_minutes = 6'd6;
    set_seconds = 6'd7;
    set_valid   = 1'b1;
    step();
    set_valid   = 1'b0;
    checks++; if (disp !== 24'h050607) begin errors++; $display("FAIL collide_load: got %h expected 050607", disp); end
    checks++; if (sec_pulse !== 1'b0) begin errors++; $display("FAIL collide_pulse: got %b expected 0", sec_pulse); end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (sec_pulse !== (i == 4)) begin errors++; $display("FAIL collide_next%0d: got %b expected %b", i, sec_pulse, i == 4); end
    end
    run = 1'b0;
    checks++; if (disp !== 24'h050608) begin errors++; $display("FAIL collide_after: got %h expected 050608", disp); end
  endtask

  task automatic test_alarm_stop();
    int rang = 0;
    alarm_hours   = 5'd7;
    alarm_minutes = 6'd0;
    alarm_load    = 1'b1;
    alarm_arm     = 1'b1;
    step();
    alarm_load    = 1'b0;
    do_set(6, 59, 59);
    run = 1'b1;
    repeat (4) step();
    checks++; if (sec_pulse !== 1'b1 || disp !== 24'h070000 || alarm_ring !== 1'b0) begin errors++; $display("FAIL alarm_edge: got pulse %b disp %h ring %b expected 1 070000 0", sec_pulse, disp, alarm_ring); end
    step();
    checks++; if (alarm_ring !== 1'b1) begin errors++; $display("FAIL alarm_rise: got %b expected 1", alarm_ring); end
    alarm_stop = 1'b1;
    step();
    alarm_stop = 1'b0;
    checks++; if (alarm_ring !== 1'b0) begin errors++; $display("FAIL alarm_stop: got %b expected 0", alarm_ring); end
    for (int i = 0; i < 260; i++) begin
      step();
      if (alarm_ring !== 1'b0) rang++;
    end
    run = 1'b0;
    checks++; if (rang != 0) begin errors++; $display("FAIL no_retrigger: got %0d ringing cycles expected 0", rang); end
    checks++; if (disp !== 24'h070105) begin errors++; $display("FAIL stop_time: got %h expected 070105", disp); end
  endtask

  task automatic test_snooze_timeout();
    alarm_hours   = 5'd8;
    alarm_minutes = 6'd0;
    alarm_load    = 1'b1;
    step();
    alarm_load    = 1'b0;
    do_set(7, 59, 59);
    run = 1'b1;
    repeat (5) step();
    checks++; if (alarm_ring !== 1'b1) begin errors++; $display("FAIL snooze_ring: got %b expected 1", alarm_ring); end
    alarm_snooze = 1'b1;
    step();
    alarm_snooze = 1'b0;
    checks++; if (alarm_ring !== 1'b0) begin errors++; $display("FAIL snooze_off: got %b expected 0", alarm_ring); end
    for (int i = 1; i <= 22; i++) begin
      step();
      checks++; if (alarm_ring !== (i >= 11 && i <= 18)) begin errors++; $display("FAIL snooze_ring%0d: got %b expected %b", i, alarm_ring, (i >= 11 && i <= 18)); end
      checks++; if (sec_pulse !== (i % 4 == 2)) begin errors++; $display("FAIL snooze_pulse%0d: got %b expected %b", i, sec_pulse, (i % 4 == 2)); end
    end
    run = 1'b0;
  endtask

  task automatic test_arm_reset_priority();
    int rang = 0;
    do_set(7, 59, 59);
    run = 1'b1;
    repeat (5) step();
    checks++; if (alarm_ring !== 1'b1) begin errors++; $display("FAIL prio_ring1: got %b expected 1", alarm_ring); end
    alarm_stop   = 1'b1;
    alarm_snooze = 1'b1;
    step();
    alarm_stop   = 1'b0;
    alarm_snooze = 1'b0;
    checks++; if (alarm_ring !== 1'b0) begin errors++; $display("FAIL stop_and_snooze: got %b expected 0", alarm_ring); end
    for (int i = 0; i < 16; i++) begin
      step();
      if (alarm_ring !== 1'b0) rang++;
    end
    checks++; if (rang != 0) begin errors++; $display("FAIL stop_beats_snooze: got %0d ringing cycles expected 0", rang); end

    do_set(7, 59, 59);
    repeat (5) step();
    checks++; if (alarm_ring !== 1'b1) begin errors++; $display("FAIL prio_ring2: got %b expected 1", alarm_ring); end
    alarm_snooze = 1'b1;
    step();
    alarm_snooze = 1'b0;
    alarm_arm    = 1'b0;
    step();
    step();
    alarm_arm    = 1'b1;
    rang = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (alarm_ring !== 1'b0) rang++;
    end
    checks++; if (rang != 0) begin errors++; $display("FAIL disarm_snoozed: got %0d ringing cycles expected 0", rang); end

    do_set(7, 59, 59);
    repeat (5) step();
    checks++; if (alarm_ring !== 1'b1) begin errors++; $display("FAIL prio_ring3: got %b expected 1", alarm_ring); end
    reset = 1'b1;
    step();
    checks++; if (alarm_ring !== 1'b0 || disp !== 24'h000000 || set_ready !== 1'b0) begin errors++; $display("FAIL reset_ringing: got ring %b disp %h ready %b expected 0 000000 0", alarm_ring, disp, set_ready); end
    reset = 1'b0;
    run   = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_invalid_set();
    test_set_tick_collision();
    test_alarm_stop();
    test_snooze_timeout();
    test_arm_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
